// File: rtl/cxl_mem_responder_if.sv
// Fill/evict link between the DRAM cache controller (master) and the CXL memory responder (slave).
interface cxl_mem_if #(
    parameter int ID_W   = 16,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
);
    logic [ID_W-1:0]   arid_i;
    logic [ADDR_W-1:0] araddr_i;
    logic              arvalid_i;
    logic              arready_o;
    logic [ID_W-1:0]   awid_i;
    logic [ADDR_W-1:0] awaddr_i;
    logic              awvalid_i;
    logic              awready_o;
    logic [ID_W-1:0]   wid_i;
    logic [DATA_W-1:0] wdata_i;
    logic              wvalid_i;
    logic              wready_o;
    logic [ID_W-1:0]   rid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              rvalid_o;
    logic              rready_i;
    logic [ID_W-1:0]   bid_o;
    logic              bvalid_o;
    logic              bready_i;

    modport slave (
        input  arid_i, araddr_i, arvalid_i, awid_i, awaddr_i, awvalid_i,
        input  wid_i, wdata_i, wvalid_i, rready_i, bready_i,
        output arready_o, awready_o, wready_o, rid_o, rdata_o, rvalid_o, bid_o, bvalid_o
    );

    modport master (
        output arid_i, araddr_i, arvalid_i, awid_i, awaddr_i, awvalid_i,
        output wid_i, wdata_i, wvalid_i, rready_i, bready_i,
        input  arready_o, awready_o, wready_o, rid_o, rdata_o, rvalid_o, bid_o, bvalid_o
    );
endinterface

// File: rtl/cxl_mem_responder.sv
// CXL-side memory responder: in-order fixed-latency line reads from a small backing
// array, and single-entry AW/W holding registers that commit evictions and answer on B.
module cxl_mem_responder #(
    parameter int ID_W     = 16,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 512,
    parameter int OFFSET_W = 6,
    parameter int DEPTH_W  = 8,
    parameter int RQ_DEPTH = 4,
    parameter int READ_LAT = 3
) (
    input logic     clk,
    input logic     rst,
    cxl_mem_if.slave bus
);
    localparam int PTR_W = $clog2(RQ_DEPTH);
    localparam int CNT_W = $clog2(RQ_DEPTH + 1);
    localparam int LAT_W = $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} rd_state_t;

    logic [DATA_W-1:0]  mem [2**DEPTH_W];
    logic [ID_W-1:0]    rq_id [RQ_DEPTH];
    logic [DEPTH_W-1:0] rq_idx [RQ_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_next;
    rd_state_t          state;
    logic [LAT_W-1:0]   cnt;
    logic               ar_fire, r_fire, aw_fire, w_fire, commit;
    logic               aw_full, w_full;
    logic [ID_W-1:0]    aw_id;
    logic [DEPTH_W-1:0] aw_idx;
    logic [DATA_W-1:0]  w_data;
    logic               unused_bits;

    // Only the index field of the address matters; wid is superseded by the AW ID.
    assign unused_bits = ^{bus.wid_i, bus.araddr_i, bus.awaddr_i};

    assign bus.arready_o = (count != CNT_W'(RQ_DEPTH));
    assign bus.awready_o = !aw_full;
    assign bus.wready_o  = !w_full;

    assign ar_fire    = bus.arvalid_i && bus.arready_o;
    assign r_fire     = bus.rvalid_o && bus.rready_i;
    assign aw_fire    = bus.awvalid_i && bus.awready_o;
    assign w_fire     = bus.wvalid_i && bus.wready_o;
    assign commit     = aw_full && w_full && (!bus.bvalid_o || bus.bready_i);
    assign count_next = count + CNT_W'(ar_fire) - CNT_W'(r_fire);

    always_ff @(posedge clk) begin
        if (ar_fire) begin
            rq_id[wr_ptr]  <= bus.arid_i;
            rq_idx[wr_ptr] <= bus.araddr_i[OFFSET_W +: DEPTH_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (ar_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (r_fire)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    // The capture reads mem with a non-blocking sample, so a same-edge commit is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bus.rvalid_o <= 1'b0;
            bus.rid_o    <= '0;
            bus.rdata_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state <= ST_WAIT;
                        cnt   <= LAT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt == LAT_W'(READ_LAT)) begin
                        bus.rdata_o  <= mem[rq_idx[rd_ptr]];
                        bus.rid_o    <= rq_id[rd_ptr];
                        bus.rvalid_o <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        cnt <= cnt + LAT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rready_i) begin
                        bus.rvalid_o <= 1'b0;
                        if (count_next != '0) begin
                            state <= ST_WAIT;
                            cnt   <= LAT_W'(1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            aw_id        <= '0;
            aw_idx       <= '0;
            w_data       <= '0;
            bus.bvalid_o <= 1'b0;
            bus.bid_o    <= '0;
        end else if (commit) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            bus.bvalid_o <= 1'b1;
            bus.bid_o    <= aw_id;
        end else begin
            if (aw_fire) begin
                aw_full <= 1'b1;
                aw_id   <= bus.awid_i;
                aw_idx  <= bus.awaddr_i[OFFSET_W +: DEPTH_W];
            end
            if (w_fire) begin
                w_full <= 1'b1;
                w_data <= bus.wdata_i;
            end
            if (bus.bready_i) bus.bvalid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem[aw_idx] <= w_data;
    end
endmodule

// File: tb/tb_cxl_mem_responder.sv
// Directed and randomized checks of cxl_mem_responder against a line-level memory model.
module tb_cxl_mem_responder;
    localparam int READ_LAT = 3;
    typedef logic [511:0] line_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    line_t model_mem [int];

    always #5 clk = ~clk;

    cxl_mem_if #(.ID_W(16), .ADDR_W(64), .DATA_W(512)) bus ();

    cxl_mem_responder #(
        .ID_W(16), .ADDR_W(64), .DATA_W(512), .OFFSET_W(6),
        .DEPTH_W(8), .RQ_DEPTH(4), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Line index = address bits above the 64-byte offset, modulo a 256-line array.
    function automatic int idx_of(input logic [63:0] addr);
        return int'((addr / 64) % 256);
    endfunction

    function automatic logic [63:0] addr_of(input int idx);
        logic [63:0] upper;
        upper = {$urandom, $urandom};
        return (upper << 14) | (64'(idx) * 64) | 64'($urandom_range(0, 63));
    endfunction

    function automatic line_t rand_line();
        line_t r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic write_line(input logic [15:0] id, input logic [63:0] addr, input line_t data,
                              input int aw_dly, input int w_dly);
        bit aw_done = 0, w_done = 0, f_aw, f_w;
        int c = 0, bw = 0;
        bus.bready_i = 1'b1;
        bus.awid_i   = id;
        bus.awaddr_i = addr;
        bus.wid_i    = id;
        bus.wdata_i  = data;
        while (!(aw_done && w_done) && c < 50) begin
            bus.awvalid_i = !aw_done && (c >= aw_dly);
            bus.wvalid_i  = !w_done && (c >= w_dly);
            f_aw = bus.awvalid_i && bus.awready_o;
            f_w  = bus.wvalid_i && bus.wready_o;
            tick();
            if (f_aw) aw_done = 1;
            if (f_w)  w_done = 1;
            c++;
        end
        bus.awvalid_i = 1'b0;
        bus.wvalid_i  = 1'b0;
        check("wr_accept", aw_done && w_done, 1);
        while (!bus.bvalid_o && bw < 20) begin
            tick();
            bw++;
        end
        check("wr_b_latency", bw, 1);
        check("wr_bid", bus.bid_o, id);
        tick();
        check("wr_b_one_cycle", bus.bvalid_o, 0);
        model_mem[idx_of(addr)] = data;
    endtask

    task automatic read_line(input logic [15:0] id, input logic [63:0] addr, input string tag);
        int c = 0, lat = 0;
        bit fired = 0;
        bus.rready_i  = 1'b1;
        bus.arid_i    = id;
        bus.araddr_i  = addr;
        bus.arvalid_i = 1'b1;
        while (!fired && c < 50) begin
            fired = bus.arready_o;
            tick();
            c++;
        end
        bus.arvalid_i = 1'b0;
        while (!bus.rvalid_o && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, READ_LAT + 1);
        check({tag, "_rid"}, bus.rid_o, id);
        check({tag, "_rdata"}, bus.rdata_o, model_mem[idx_of(addr)]);
        tick();
        check({tag, "_rvalid_drop"}, bus.rvalid_o, 0);
    endtask

    logic [15:0] exp_id [$];
    line_t       exp_data [$];
    line_t       line_a, line_b;
    int          acc, got, cnt, issued, nreq, cur_idx, stale;
    bit          f_ar, f_r, f_w;

    initial begin
        bus.arid_i = '0; bus.araddr_i = '0; bus.arvalid_i = 1'b0;
        bus.awid_i = '0; bus.awaddr_i = '0; bus.awvalid_i = 1'b0;
        bus.wid_i = '0; bus.wdata_i = '0; bus.wvalid_i = 1'b0;
        bus.rready_i = 1'b0; bus.bready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_arready", bus.arready_o, 1);
        check("rst_awready", bus.awready_o, 1);
        check("rst_wready", bus.wready_o, 1);
        check("rst_rvalid", bus.rvalid_o, 0);
        check("rst_bvalid", bus.bvalid_o, 0);
        check("rst_rid", bus.rid_o, 0);
        check("rst_rdata", bus.rdata_o, 0);
        check("rst_bid", bus.bid_o, 0);

        // Write then read
        write_line(16'h5, 64'h40, {8{64'hDDDD_DDDD_DDDD_DDDD}}, 0, 0);
        read_line(16'h7, 64'h40, "wr_rd");

        // Queue full and backpressure
        bus.rready_i = 1'b0;
        acc = 0; cnt = 0;
        while (acc < 4 && cnt < 40) begin
            bus.arvalid_i = 1'b1;
            bus.arid_i    = 16'(acc + 1);
            bus.araddr_i  = 64'h40;
            f_ar = bus.arready_o;
            tick();
            if (f_ar) acc++;
            cnt++;
        end
        bus.arid_i = 16'd5;
        check("q_back_to_back", cnt, 4);
        check("q_full_arready", bus.arready_o, 0);
        cnt = 0;
        while (!bus.rvalid_o && cnt < 50) begin tick(); cnt++; end
        check("q_first_rid", bus.rid_o, 1);
        tick(); tick();
        check("q_hold_rvalid", bus.rvalid_o, 1);
        check("q_hold_rid", bus.rid_o, 1);
        check("q_hold_arready", bus.arready_o, 0);
        bus.rready_i = 1'b1;
        got = 0; cnt = 0;
        while (got < 5 && cnt < 100) begin
            f_ar = bus.arvalid_i && bus.arready_o;
            f_r  = bus.rvalid_o && bus.rready_i;
            if (f_r) begin
                check("q_order_rid", bus.rid_o, got + 1);
                check("q_order_rdata", bus.rdata_o, model_mem[1]);
                got++;
            end
            if (f_ar) check("q_fifth_after_pop", got > 0, 1);
            tick();
            if (f_ar) bus.arvalid_i = 1'b0;
            cnt++;
        end
        check("q_all_responses", got, 5);
        check("q_fifth_accepted", bus.arvalid_i, 0);

        // Split write: W three cycles ahead of AW, B held by bready low
        line_a = rand_line();
        bus.bready_i = 1'b0;
        bus.wdata_i = line_a; bus.wvalid_i = 1'b1;
        bus.awid_i = 16'h9; bus.awaddr_i = 64'hC0;
        tick();
        bus.wvalid_i = 1'b0;
        check("split_wready_held", bus.wready_o, 0);
        tick(); tick();
        check("split_wready_still", bus.wready_o, 0);
        check("split_no_b_yet", bus.bvalid_o, 0);
        bus.awvalid_i = 1'b1;
        tick();
        bus.awvalid_i = 1'b0;
        check("split_b_not_early", bus.bvalid_o, 0);
        tick();
        check("split_b_commit", bus.bvalid_o, 1);
        check("split_bid", bus.bid_o, 16'h9);
        repeat (3) tick();
        check("split_b_held", bus.bvalid_o, 1);
        check("split_bid_stable", bus.bid_o, 16'h9);
        bus.bready_i = 1'b1;
        tick();
        check("split_b_drop", bus.bvalid_o, 0);
        model_mem[3] = line_a;
        read_line(16'hA, 64'hC0, "split_rd");

        // Aliasing above the index field
        write_line(16'h11, 64'h40, {64{8'hAA}}, 0, 0);
        write_line(16'h12, 64'h40 + (64'd1 << 14), {64{8'hBB}}, 1, 0);
        check("alias_model", model_mem[1], {64{8'hBB}});
        read_line(16'h13, 64'h40, "alias_rd");

        // Same-edge hazard: commit and capture of idx 2 on one edge
        line_a = rand_line();
        line_b = rand_line();
        write_line(16'h20, 64'h80, line_a, 0, 0);
        bus.rready_i = 1'b1; bus.bready_i = 1'b1;
        bus.arid_i = 16'h21; bus.araddr_i = 64'h80; bus.arvalid_i = 1'b1;
        tick();
        bus.arvalid_i = 1'b0;
        tick(); tick();
        bus.awid_i = 16'h22; bus.awaddr_i = 64'h80; bus.wdata_i = line_b;
        bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1;
        tick();
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        tick();
        check("haz_rvalid", bus.rvalid_o, 1);
        check("haz_old_data", bus.rdata_o, line_a);
        check("haz_bvalid", bus.bvalid_o, 1);
        check("haz_bid", bus.bid_o, 16'h22);
        tick();
        model_mem[2] = line_b;
        read_line(16'h23, 64'h80, "haz_reread");

        // Randomized traffic
        for (int i = 0; i < 8; i++)
            write_line(16'($urandom), addr_of(i), rand_line(), $urandom_range(0, 3), $urandom_range(0, 3));
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                write_line(16'($urandom), addr_of($urandom_range(0, 7)), rand_line(),
                           $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                nreq = $urandom_range(1, 6);
                issued = 0; got = 0; cnt = 0; cur_idx = 0;
                while (got < nreq && cnt < 400) begin
                    if (!bus.arvalid_i && issued < nreq && $urandom_range(0, 2) != 0) begin
                        cur_idx = $urandom_range(0, 7);
                        bus.arvalid_i = 1'b1;
                        bus.arid_i    = 16'($urandom);
                        bus.araddr_i  = addr_of(cur_idx);
                    end
                    bus.rready_i = ($urandom_range(0, 3) != 0);
                    f_ar = bus.arvalid_i && bus.arready_o;
                    f_r  = bus.rvalid_o && bus.rready_i;
                    if (f_r) begin
                        if (exp_id.size() == 0) begin
                            check("rand_spurious_r", 1, 0);
                        end else begin
                            check("rand_rid", bus.rid_o, exp_id.pop_front());
                            check("rand_rdata", bus.rdata_o, exp_data.pop_front());
                        end
                        got++;
                    end
                    if (f_ar) begin
                        exp_id.push_back(bus.arid_i);
                        exp_data.push_back(model_mem[cur_idx]);
                        issued++;
                    end
                    tick();
                    if (f_ar) bus.arvalid_i = 1'b0;
                    cnt++;
                end
                check("rand_burst_done", got, nreq);
                bus.rready_i = 1'b1;
            end
        end

        // Reset mid-operation
        bus.rready_i = 1'b0;
        acc = 0; cnt = 0;
        while (acc < 2 && cnt < 20) begin
            bus.arvalid_i = 1'b1;
            bus.arid_i = 16'(16'h30 + acc);
            bus.araddr_i = 64'h40;
            f_ar = bus.arready_o;
            tick();
            if (f_ar) acc++;
            cnt++;
        end
        bus.arvalid_i = 1'b0;
        cnt = 0;
        while (!bus.rvalid_o && cnt < 50) begin tick(); cnt++; end
        check("mid_resp_reached", bus.rvalid_o, 1);
        bus.awid_i = 16'h33; bus.awaddr_i = 64'h100; bus.awvalid_i = 1'b1;
        tick();
        bus.awvalid_i = 1'b0;
        check("mid_aw_held", bus.awready_o, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rvalid", bus.rvalid_o, 0);
        check("mid_rst_bvalid", bus.bvalid_o, 0);
        tick(); tick();
        rst = 1'b0;
        check("mid_rel_arready", bus.arready_o, 1);
        check("mid_rel_awready", bus.awready_o, 1);
        check("mid_rel_wready", bus.wready_o, 1);
        line_a = rand_line();
        bus.rready_i = 1'b1; bus.bready_i = 1'b1;
        bus.wdata_i = line_a; bus.wvalid_i = 1'b1;
        stale = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.rvalid_o || bus.bvalid_o) stale++;
            f_w = bus.wvalid_i && bus.wready_o;
            tick();
            if (f_w) bus.wvalid_i = 1'b0;
        end
        check("mid_no_stale", stale, 0);
        bus.awid_i = 16'h34; bus.awaddr_i = 64'h100; bus.awvalid_i = 1'b1;
        tick();
        bus.awvalid_i = 1'b0;
        cnt = 0;
        while (!bus.bvalid_o && cnt < 20) begin tick(); cnt++; end
        check("mid_after_b", bus.bvalid_o, 1);
        check("mid_after_bid", bus.bid_o, 16'h34);
        tick();
        model_mem[4] = line_a;
        read_line(16'h35, 64'h100, "mid_after_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
